pipeline_elastic_buffer: RTL and testbench

Parametrised elastic pipeline buffer for valid/backpressure (LI) channels: a circular store of `Depth` tokens of `Width` bits. It has an optional zero-latency bypass when empty, a synchronous flush, and an occupancy output. It sits between pipeline stages wherever more than two slots of slack, latch-style transparency, or flush-on-redirect is needed. It replaces ad-hoc chains of fixed two-slot registers.

---
 rtl/pipeline_elastic_buffer_pkg.sv | 17 +
 rtl/pipeline_elastic_buffer.sv | 99 +++++++++
 tb/tb_pipeline_elastic_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipeline_elastic_buffer_pkg.sv
// Shared helpers for the elastic buffer: width calculation and parameter sanity check.
package pipeline_pkg;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic bit params_valid(input int depth, input int width);
    return (depth >= 1) && (width >= 1);
  endfunction

endpackage

// File: rtl/pipeline_elastic_buffer.sv
// Elastic valid/backpressure buffer: circular store of Depth tokens with optional
// zero-latency bypass when empty, synchronous flush and an occupancy count.
module pipeline_elastic_buffer
  import pipeline_pkg::*;
#(
  parameter string Name   = "",
  parameter int    Width  = 8,
  parameter int    Depth  = 2,
  parameter int    Bypass = 0,
  localparam int   PW     = clog2_min1(Depth),
  localparam int   CW     = clog2_min1(Depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  input  logic             d_valid,
  output logic             d_bp,
  output logic [Width-1:0] q,
  output logic             q_valid,
  input  logic             q_bp,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam bit ParamsOk = params_valid(Depth, Width);

  if (!ParamsOk) begin : g_param_guard
    $error("%s: Depth and Width must both be at least 1", Name);
  end

  logic [Width-1:0] data_q [Depth];
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, bypass_now, accept, push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full       = (count_q == CW'(Depth));
    empty      = (count_q == '0);
    bypass_now = (Bypass != 0) && empty;
    d_bp       = full || flush || reset;
    accept     = d_valid && !d_bp;

    if (bypass_now) begin
      q       = d;
      q_valid = d_valid && !flush && !reset;
    end else begin
      q       = data_q[rp_q];
      q_valid = !empty && !flush && !reset;
    end

    // A bypassed token that leaves immediately is never written to storage.
    push = accept && !(bypass_now && !q_bp);
    pop  = !bypass_now && q_valid && !q_bp;

    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;

    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = ptr_inc(wp_q);
      if (pop)  rp_d = ptr_inc(rp_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; a slot only matters once it has been written.
  always_ff @(posedge clk) begin
    if (push) data_q[wp_q] <= d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipeline_elastic_buffer.sv
// Bench for pipeline_elastic_buffer: a queue-based reference model checks two
// instances (Depth=4 registered, Depth=3 with bypass) under directed and random traffic.
module tb_pipeline_elastic_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in    [2];
  logic       d_valid [2];
  logic       q_bp    [2];
  logic       flush   [2];
  logic [7:0] q_out   [2];
  logic       q_valid [2];
  logic       d_bp    [2];
  logic [2:0] count_a;
  logic [1:0] count_b;

  always #5 clk = ~clk;

  pipeline_elastic_buffer #(.Name("buf_a"), .Width(8), .Depth(4), .Bypass(0)) u_buf_a (
    .clk(clk), .reset(reset), .d(d_in[0]), .d_valid(d_valid[0]), .d_bp(d_bp[0]),
    .q(q_out[0]), .q_valid(q_valid[0]), .q_bp(q_bp[0]), .flush(flush[0]), .count(count_a)
  );

  pipeline_elastic_buffer #(.Name("buf_b"), .Width(8), .Depth(3), .Bypass(1)) u_buf_b (
    .clk(clk), .reset(reset), .d(d_in[1]), .d_valid(d_valid[1]), .d_bp(d_bp[1]),
    .q(q_out[1]), .q_valid(q_valid[1]), .q_bp(q_bp[1]), .flush(flush[1]), .count(count_b)
  );

  logic [7:0] model_q [2][$];
  int         depth_of [2] = '{4, 3};
  bit         bypass_of [2] = '{1'b0, 1'b1};
  logic [7:0] tok [2];
  bit         s_empty [2];
  bit         s_bp [2];
  bit         s_valid [2];
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input bit dv, input logic [7:0] dat,
                                input bit bp, input bit fl);
    d_valid[i] = dv;
    d_in[i]    = dat;
    q_bp[i]    = bp;
    flush[i]   = fl;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) apply_stimulus(i, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Check outputs mid-cycle against the model, then advance the model on the edge.
  task automatic tick();
    logic [31:0] cnt;
    bit          acc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s_empty[i] = (model_q[i].size() == 0);
      s_bp[i]    = (model_q[i].size() == depth_of[i]) || flush[i] || reset;
      if (bypass_of[i] && s_empty[i]) s_valid[i] = d_valid[i] && !flush[i] && !reset;
      else                            s_valid[i] = !s_empty[i] && !flush[i] && !reset;
      cnt = (i == 0) ? 32'(count_a) : 32'(count_b);
      check_output($sformatf("u%0d.d_bp", i), 32'(d_bp[i]), 32'(s_bp[i]));
      check_output($sformatf("u%0d.q_valid", i), 32'(q_valid[i]), 32'(s_valid[i]));
      check_output($sformatf("u%0d.count", i), cnt, 32'(model_q[i].size()));
      if (s_valid[i])
        check_output($sformatf("u%0d.q", i), 32'(q_out[i]),
                     (bypass_of[i] && s_empty[i]) ? 32'(d_in[i]) : 32'(model_q[i][0]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset || flush[i]) begin
        model_q[i].delete();
      end else begin
        acc = d_valid[i] && !s_bp[i];
        if (bypass_of[i] && s_empty[i]) begin
          if (acc && q_bp[i]) model_q[i].push_back(d_in[i]);
        end else begin
          if (s_valid[i] && !q_bp[i]) void'(model_q[i].pop_front());
          if (acc) model_q[i].push_back(d_in[i]);
        end
        if (acc) tok[i] = tok[i] + 8'd1;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    tok   = '{8'd0, 8'd0};
    idle_all();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] fill Depth=4 with backpressure, then drain");
    apply_stimulus(0, 1'b1, 8'h11, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'h22, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'h33, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'h44, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'h55, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'h66, 1'b0, 1'b0); tick();
    apply_stimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) tick();

    $display("[TB] flush with three stored tokens");
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(0, 1'b1, 8'(8'hA0 + n), 1'b1, 1'b0);
      tick();
    end
    apply_stimulus(0, 1'b1, 8'h99, 1'b1, 1'b1); tick();
    apply_stimulus(0, 1'b1, 8'h7E, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    tick();

    $display("[TB] reset mid-stream");
    apply_stimulus(0, 1'b1, 8'hC1, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b1, 8'hC2, 1'b1, 1'b0); tick();
    apply_stimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    tick();

    $display("[TB] bypass when empty");
    apply_stimulus(1, 1'b1, 8'hA5, 1'b0, 1'b0); tick();
    apply_stimulus(1, 1'b1, 8'hA5, 1'b1, 1'b0); tick();
    apply_stimulus(1, 1'b0, 8'h00, 1'b1, 1'b0); tick();
    tick();
    apply_stimulus(1, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    tick();

    $display("[TB] random traffic on both instances");
    tok = '{8'd0, 8'd0};
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++)
        apply_stimulus(i, $urandom_range(0, 3) != 0, tok[i], $urandom_range(0, 2) == 0,
                       $urandom_range(0, 63) == 0);
      tick();
    end
    idle_all();
    for (int n = 0; n < 6; n++) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
